// File: rtl/bgr_frame_ctrl.sv
// Frame controller: gates pixels into the datapath, tags and aligns returned masks (DP_LATENCY cycles), counts foreground.
// Backpressure: o_READY high only while the frame is running; pixels offered outside RUN are not accepted.
module bgr_frame_ctrl #(
   parameter int H_ACTIVE   = 640,
   parameter int V_ACTIVE   = 480,
   parameter int DP_LATENCY = 2
) (
   input  logic        i_CLK,
   input  logic        i_RST,
   input  logic        i_START,
   input  logic [7:0]  i_H_THRESHOLD,
   input  logic [23:0] i_DATA_RGB,
   input  logic        i_DATA_VALID,
   output logic        o_READY,
   output logic [23:0] o_DP_DATA_RGB,
   output logic        o_DP_DATA_VALID,
   output logic [7:0]  o_DP_H_THRESHOLD,
   input  logic        i_DP_MASK,
   output logic        o_MASK,
   output logic        o_MASK_VALID,
   output logic        o_EOL,
   output logic        o_EOF,
   output logic [19:0] o_FG_COUNT,
   output logic        o_BUSY,
   output logic        o_DONE
);

   localparam int CW = (H_ACTIVE > 1) ? $clog2(H_ACTIVE) : 1;
   localparam int RW = (V_ACTIVE > 1) ? $clog2(V_ACTIVE) : 1;
   localparam logic [CW-1:0] COL_LAST = CW'(H_ACTIVE - 1);
   localparam logic [RW-1:0] ROW_LAST = RW'(V_ACTIVE - 1);

   typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

   state_t                      state;
   logic [CW-1:0]               col;
   logic [RW-1:0]               row;
   logic [DP_LATENCY-1:0][2:0]  tag_q;
   logic                        accept;
   logic                        last_col;
   logic                        last_row;

   assign accept          = i_DATA_VALID & o_READY;
   assign last_col        = (col == COL_LAST);
   assign last_row        = (row == ROW_LAST);
   assign o_DP_DATA_RGB   = i_DATA_RGB;
   assign o_DP_DATA_VALID = accept;

   // Tag stages carry {valid, eol, eof}; the last stage lines up with i_DP_MASK.
   assign {o_MASK_VALID, o_EOL, o_EOF} = tag_q[DP_LATENCY-1];
   assign o_MASK = i_DP_MASK & o_MASK_VALID;

   always_ff @(posedge i_CLK) begin
      if (i_RST) begin
         state            <= IDLE;
         o_READY          <= 1'b0;
         o_BUSY           <= 1'b0;
         o_DONE           <= 1'b0;
         col              <= '0;
         row              <= '0;
         tag_q            <= '0;
         o_DP_H_THRESHOLD <= '0;
         o_FG_COUNT       <= '0;
      end else begin
         tag_q[0] <= {accept, accept & last_col, accept & last_col & last_row};
         for (int i = DP_LATENCY - 1; i > 0; i--) begin
            tag_q[i] <= tag_q[i-1];
         end
         if (o_MASK) begin
            o_FG_COUNT <= o_FG_COUNT + 20'd1;
         end
         o_DONE <= 1'b0;
         case (state)
            IDLE: begin
               if (i_START) begin
                  state            <= RUN;
                  o_READY          <= 1'b1;
                  o_BUSY           <= 1'b1;
                  o_DP_H_THRESHOLD <= i_H_THRESHOLD;
                  o_FG_COUNT       <= '0;
                  col              <= '0;
                  row              <= '0;
               end
            end
            RUN: begin
               if (accept) begin
                  if (last_col) begin
                     col <= '0;
                     if (last_row) begin
                        row     <= '0;
                        state   <= DRAIN;
                        o_READY <= 1'b0;
                     end else begin
                        row <= row + RW'(1);
                     end
                  end else begin
                     col <= col + CW'(1);
                  end
               end
            end
            DRAIN: begin
               // The last pixel's mask leaves the pipe together with its eof tag.
               if (o_EOF) begin
                  state  <= DONE;
                  o_BUSY <= 1'b0;
                  o_DONE <= 1'b1;
               end
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_bgr_frame_ctrl.sv
// Directed bench for bgr_frame_ctrl on a 4x2 frame; datapath model returns r[0] two cycles after acceptance.
module tb_bgr_frame_ctrl;

   logic        i_CLK = 1'b0;
   logic        i_RST = 1'b0;
   logic        i_START = 1'b0;
   logic [7:0]  i_H_THRESHOLD = 8'd0;
   logic [23:0] i_DATA_RGB = 24'd0;
   logic        i_DATA_VALID = 1'b0;
   logic        o_READY;
   logic [23:0] o_DP_DATA_RGB;
   logic        o_DP_DATA_VALID;
   logic [7:0]  o_DP_H_THRESHOLD;
   logic        i_DP_MASK;
   logic        o_MASK;
   logic        o_MASK_VALID;
   logic        o_EOL;
   logic        o_EOF;
   logic [19:0] o_FG_COUNT;
   logic        o_BUSY;
   logic        o_DONE;

   bgr_frame_ctrl #(.H_ACTIVE(4), .V_ACTIVE(2), .DP_LATENCY(2)) dut (
      .i_CLK(i_CLK), .i_RST(i_RST), .i_START(i_START), .i_H_THRESHOLD(i_H_THRESHOLD),
      .i_DATA_RGB(i_DATA_RGB), .i_DATA_VALID(i_DATA_VALID), .o_READY(o_READY),
      .o_DP_DATA_RGB(o_DP_DATA_RGB), .o_DP_DATA_VALID(o_DP_DATA_VALID),
      .o_DP_H_THRESHOLD(o_DP_H_THRESHOLD), .i_DP_MASK(i_DP_MASK), .o_MASK(o_MASK),
      .o_MASK_VALID(o_MASK_VALID), .o_EOL(o_EOL), .o_EOF(o_EOF),
      .o_FG_COUNT(o_FG_COUNT), .o_BUSY(o_BUSY), .o_DONE(o_DONE)
   );

   always #5 i_CLK = ~i_CLK;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;
   logic [1:0] dp_pipe = 2'b00;
   logic [7:0] rpat = 8'b0100_1101;   // r[0] of pixels 0..7 = 1,0,1,1,0,0,1,0

   int acc_q[$];
   int mv_q[$];
   bit mk_q[$];
   bit eol_q[$];
   bit eof_q[$];

   always @(posedge i_CLK) cyc <= cyc + 1;

   always @(posedge i_CLK) dp_pipe <= {dp_pipe[0], o_DP_DATA_VALID & o_DP_DATA_RGB[0]};
   assign i_DP_MASK = dp_pipe[1];

   always @(negedge i_CLK) begin
      if (o_DP_DATA_VALID) acc_q.push_back(cyc);
      if (o_MASK_VALID) begin
         mv_q.push_back(cyc);
         mk_q.push_back(o_MASK);
         eol_q.push_back(o_EOL);
         eof_q.push_back(o_EOF);
      end
   end

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0d want %0d", tag, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge i_CLK);
      #1;
   endtask

   task automatic clear_log();
      acc_q.delete(); mv_q.delete(); mk_q.delete(); eol_q.delete(); eof_q.delete();
   endtask

   task automatic start_frame(input logic [7:0] thr);
      clear_log();
      i_H_THRESHOLD = thr;
      i_START = 1'b1;
      tick();
      i_START = 1'b0;
      chk("start_busy", o_BUSY, 1);
      chk("start_fg_clear", o_FG_COUNT, 0);
      chk("start_thr", o_DP_H_THRESHOLD, thr);
   endtask

   task automatic send_pixels(input int n, input int gap_at, input int gap_len, input int restart_at);
      for (int i = 0; i < n; i++) begin
         if (i == gap_at) begin
            i_DATA_VALID = 1'b0;
            repeat (gap_len) tick();
         end
         i_DATA_VALID = 1'b1;
         i_DATA_RGB   = {8'hB0 + 8'(i), 8'h5A, 7'h31, rpat[i]};
         if (i == restart_at) begin
            i_START = 1'b1;
            i_H_THRESHOLD = 8'd99;
         end
         #1;
         chk("px_ready", o_READY, 1);
         tick();
         i_START = 1'b0;
      end
      i_DATA_VALID = 1'b0;
   endtask

   task automatic finish_frame(input logic [7:0] thr);
      int done_cyc;
      bit seen;
      done_cyc = -1;
      seen = 0;
      chk("drain_ready", o_READY, 0);
      for (int k = 0; k < 30 && !seen; k++) begin
         if (o_DONE) begin
            seen = 1;
            done_cyc = cyc;
         end else begin
            tick();
         end
      end
      chk("done_seen", seen, 1);
      i_DATA_VALID = 1'b1;
      #1;
      chk("done_busy", o_BUSY, 0);
      chk("done_ready", o_READY, 0);
      chk("done_dpvalid", o_DP_DATA_VALID, 0);
      chk("mv_count", mv_q.size(), 8);
      chk("acc_count", acc_q.size(), 8);
      for (int i = 0; i < 8 && i < mv_q.size() && i < acc_q.size(); i++) begin
         chk($sformatf("lat%0d", i), mv_q[i] - acc_q[i], 2);
         chk($sformatf("mask%0d", i), mk_q[i], rpat[i]);
         chk($sformatf("eol%0d", i), eol_q[i], (i == 3 || i == 7) ? 1 : 0);
         chk($sformatf("eof%0d", i), eof_q[i], (i == 7) ? 1 : 0);
      end
      if (mv_q.size() == 8) chk("done_after_eof", done_cyc - mv_q[7], 1);
      chk("fg_count", o_FG_COUNT, 4);
      chk("thr_frame", o_DP_H_THRESHOLD, thr);
      // Valid still high in IDLE: must not be accepted, results held.
      repeat (3) tick();
      chk("idle_done", o_DONE, 0);
      chk("idle_busy", o_BUSY, 0);
      chk("idle_ready", o_READY, 0);
      chk("idle_dpvalid", o_DP_DATA_VALID, 0);
      chk("idle_fg_hold", o_FG_COUNT, 4);
      chk("idle_thr_hold", o_DP_H_THRESHOLD, thr);
      chk("idle_no_accept", acc_q.size(), 8);
      i_DATA_VALID = 1'b0;
   endtask

   initial begin
      #50000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "watchdog");
   end

   initial begin
      // Reset with valid offered: nothing may leak out.
      i_RST = 1'b1;
      i_DATA_VALID = 1'b1;
      tick();
      tick();
      chk("rst_ready", o_READY, 0);
      chk("rst_dpvalid", o_DP_DATA_VALID, 0);
      chk("rst_busy", o_BUSY, 0);
      chk("rst_done", o_DONE, 0);
      chk("rst_mv", o_MASK_VALID, 0);
      chk("rst_mask", o_MASK, 0);
      chk("rst_eol", o_EOL, 0);
      chk("rst_eof", o_EOF, 0);
      chk("rst_fg", o_FG_COUNT, 0);
      chk("rst_thr", o_DP_H_THRESHOLD, 0);
      // Reset and start together: reset wins.
      i_START = 1'b1;
      i_H_THRESHOLD = 8'd77;
      tick();
      i_RST = 1'b0;
      i_START = 1'b0;
      i_DATA_VALID = 1'b0;
      tick();
      chk("rst_start_busy", o_BUSY, 0);
      chk("rst_start_thr", o_DP_H_THRESHOLD, 0);

      // Back-to-back frame.
      start_frame(8'd50);
      send_pixels(8, -1, 0, -1);
      finish_frame(8'd50);

      // Gap of 5 idle cycles after pixel 3.
      start_frame(8'd50);
      send_pixels(8, 3, 5, -1);
      finish_frame(8'd50);

      // Start re-pulsed mid-frame with another threshold: ignored.
      start_frame(8'd50);
      send_pixels(8, -1, 0, 2);
      chk("restart_thr", o_DP_H_THRESHOLD, 50);
      finish_frame(8'd50);

      // Reset after pixel 5: in-flight pixel 4 mask must never appear.
      start_frame(8'd50);
      send_pixels(5, -1, 0, -1);
      i_RST = 1'b1;
      i_DATA_VALID = 1'b1;
      tick();
      chk("mid_rst_ready", o_READY, 0);
      chk("mid_rst_dpvalid", o_DP_DATA_VALID, 0);
      chk("mid_rst_busy", o_BUSY, 0);
      chk("mid_rst_mv", o_MASK_VALID, 0);
      chk("mid_rst_fg", o_FG_COUNT, 0);
      chk("mid_rst_thr", o_DP_H_THRESHOLD, 0);
      i_RST = 1'b0;
      i_DATA_VALID = 1'b0;
      repeat (5) tick();
      chk("mid_rst_mv_total", mv_q.size(), 4);
      chk("mid_rst_idle_busy", o_BUSY, 0);

      // Clean frame after the abort.
      start_frame(8'd33);
      send_pixels(8, -1, 0, -1);
      finish_frame(8'd33);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
